// File: rtl/tl_xbar_pkg.sv
// Shared TileLink-UL opcode constants and beat-count helpers for the crossbar demux.
package tl_xbar_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  // Wide enough for 2^15 bytes at 8-bit data, the worst case of a 4-bit size field.
  localparam int unsigned BEAT_W = 16;

  function automatic logic [BEAT_W-1:0] num_beats(input int unsigned size,
                                                  input int unsigned data_w);
    int unsigned nb;
    nb = (32'd1 << size) / (data_w / 8);
    if (nb == 0) nb = 1;
    return BEAT_W'(nb);
  endfunction

  function automatic logic has_data_a(input logic [2:0] opcode);
    return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL);
  endfunction

  function automatic logic has_data_d(input logic [2:0] opcode);
    return opcode == ACK_DATA;
  endfunction

endpackage

// File: rtl/tl_xbar_demux_if.sv
// TileLink-UL A/D channel bundle, N lanes packed side by side; lane i at slice i.
interface tl_xbar_demux_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SIZE_W = 4,
  parameter int unsigned SINK_W = 3
);
  logic [N-1:0]          a_ready;
  logic [N-1:0]          a_valid;
  logic [N*3-1:0]        a_bits_opcode;
  logic [N*SIZE_W-1:0]   a_bits_size;
  logic [N*ADDR_W-1:0]   a_bits_address;
  logic [N*DATA_W/8-1:0] a_bits_mask;
  logic [N*DATA_W-1:0]   a_bits_data;
  logic [N-1:0]          d_ready;
  logic [N-1:0]          d_valid;
  logic [N*3-1:0]        d_bits_opcode;
  logic [N*2-1:0]        d_bits_param;
  logic [N*SIZE_W-1:0]   d_bits_size;
  logic [N*SINK_W-1:0]   d_bits_sink;
  logic [N-1:0]          d_bits_denied;
  logic [N*DATA_W-1:0]   d_bits_data;
  logic [N-1:0]          d_bits_corrupt;

  modport master (
    output a_valid, a_bits_opcode, a_bits_size, a_bits_address, a_bits_mask, a_bits_data,
    output d_ready,
    input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_sink,
    input  d_bits_denied, d_bits_data, d_bits_corrupt
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_size, a_bits_address, a_bits_mask, a_bits_data,
    input  d_ready,
    output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_sink,
    output d_bits_denied, d_bits_data, d_bits_corrupt
  );
endinterface

// File: rtl/tl_xbar_err_slave.sv
// Denied responder for unmapped requests: swallows every A beat, then answers once.
module tl_xbar_err_slave
  import tl_xbar_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SIZE_W = 4,
  parameter int unsigned SINK_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [SIZE_W-1:0] a_size_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_param_o,
  output logic [SIZE_W-1:0] d_size_o,
  output logic [SINK_W-1:0] d_sink_o,
  output logic              d_denied_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_corrupt_o
);
  localparam logic StAcc = 1'b0;
  localparam logic StRsp = 1'b1;

  logic              state_q, state_d;
  logic              is_get_q, is_get_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [BEAT_W-1:0] a_total;

  always_comb begin
    state_d  = state_q;
    is_get_d = is_get_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    a_total  = has_data_a(a_opcode_i) ? num_beats(32'(a_size_i), DATA_W) : BEAT_W'(1);
    unique case (state_q)
      StAcc: begin
        if (a_valid_i) begin
          if (cnt_q == '0) begin
            is_get_d = (a_opcode_i == GET);
            size_d   = a_size_i;
            if (a_total == BEAT_W'(1)) begin
              state_d = StRsp;
              // A Get answers with as many data beats as it asked for.
              cnt_d   = (a_opcode_i == GET) ? num_beats(32'(a_size_i), DATA_W) : BEAT_W'(1);
            end else begin
              cnt_d = a_total - BEAT_W'(1);
            end
          end else if (cnt_q == BEAT_W'(1)) begin
            state_d = StRsp;
            cnt_d   = BEAT_W'(1);
          end else begin
            cnt_d = cnt_q - BEAT_W'(1);
          end
        end
      end
      default: begin
        if (d_ready_i) begin
          if (cnt_q == BEAT_W'(1)) begin
            state_d = StAcc;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - BEAT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StAcc;
      is_get_q <= 1'b0;
      size_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_get_q <= is_get_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a_ready_o   = (state_q == StAcc);
  assign d_valid_o   = (state_q == StRsp);
  assign d_opcode_o  = is_get_q ? ACK_DATA : ACK;
  assign d_param_o   = 2'd0;
  assign d_size_o    = size_q;
  assign d_sink_o    = '0;
  assign d_denied_o  = 1'b1;
  assign d_data_o    = '0;
  assign d_corrupt_o = is_get_q;

endmodule

// File: rtl/tl_xbar_demux.sv
// 1:N TileLink-UL demux with target lock and outstanding limit.
// TL_XBAR_ERROR_SLAVE_EN adds a denied responder for unmapped addresses.
module tl_xbar_demux
  import tl_xbar_pkg::*;
#(
  parameter int unsigned N_OUT   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SIZE_W  = 4,
  parameter int unsigned SINK_W  = 3,
  parameter int unsigned MAX_OUT = 4,
  parameter logic [N_OUT*ADDR_W-1:0] ADDR_BASE = {32'h4000, 32'h3000, 32'h2000, 32'h1000},
  parameter logic [N_OUT*ADDR_W-1:0] ADDR_MASK = {4{32'h0000_0fff}}
) (
  input  logic     clock,
  input  logic     reset,
  tl_xbar_demux_if.slave  auto_in,
  tl_xbar_demux_if.master auto_out
);
`ifdef TL_XBAR_ERROR_SLAVE_EN
  localparam int unsigned ERR = 1;
  localparam int unsigned UNMAPPED = N_OUT;
`else
  localparam int unsigned ERR = 0;
  localparam int unsigned UNMAPPED = 0;
`endif
  localparam int unsigned NT    = N_OUT + ERR;
  localparam int unsigned TGT_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned NA    = 1 << TGT_W;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  logic              t_a_ready [NA];
  logic              t_d_valid [NA];
  logic [2:0]        t_d_opcode [NA];
  logic [1:0]        t_d_param [NA];
  logic [SIZE_W-1:0] t_d_size [NA];
  logic [SINK_W-1:0] t_d_sink [NA];
  logic              t_d_denied [NA];
  logic [DATA_W-1:0] t_d_data [NA];
  logic              t_d_corrupt [NA];

  logic [TGT_W-1:0]  tgt_q, tgt_d, dec_idx, tgt_eff;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [BEAT_W-1:0] a_beats_q, a_beats_d, d_beats_q, d_beats_d;
  logic              locked_q, locked_d;
  logic              found, admit, a_go, a_ready_int, d_valid_int, a_fire, d_fire;
  logic              a_last, d_last;
  logic [BEAT_W-1:0] a_first, d_first;

  for (genvar i = 0; i < N_OUT; i++) begin : g_port
    assign t_a_ready[i]         = auto_out.a_ready[i];
    assign t_d_valid[i]         = auto_out.d_valid[i];
    assign t_d_opcode[i]        = auto_out.d_bits_opcode[i*3 +: 3];
    assign t_d_param[i]         = auto_out.d_bits_param[i*2 +: 2];
    assign t_d_size[i]          = auto_out.d_bits_size[i*SIZE_W +: SIZE_W];
    assign t_d_sink[i]          = auto_out.d_bits_sink[i*SINK_W +: SINK_W];
    assign t_d_denied[i]        = auto_out.d_bits_denied[i];
    assign t_d_data[i]          = auto_out.d_bits_data[i*DATA_W +: DATA_W];
    assign t_d_corrupt[i]       = auto_out.d_bits_corrupt[i];
    assign auto_out.a_valid[i]  = a_go & (tgt_eff == TGT_W'(i));
    assign auto_out.d_ready[i]  = d_valid_int & auto_in.d_ready[0] & (tgt_q == TGT_W'(i));
  end

  for (genvar i = NT; i < NA; i++) begin : g_pad
    assign t_a_ready[i]   = 1'b0;
    assign t_d_valid[i]   = 1'b0;
    assign t_d_opcode[i]  = '0;
    assign t_d_param[i]   = '0;
    assign t_d_size[i]    = '0;
    assign t_d_sink[i]    = '0;
    assign t_d_denied[i]  = 1'b0;
    assign t_d_data[i]    = '0;
    assign t_d_corrupt[i] = 1'b0;
  end

`ifdef TL_XBAR_ERROR_SLAVE_EN
  tl_xbar_err_slave #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W),
    .SINK_W (SINK_W)
  ) u_err (
    .clock       (clock),
    .reset       (reset),
    .a_valid_i   (a_go & (tgt_eff == TGT_W'(N_OUT))),
    .a_ready_o   (t_a_ready[N_OUT]),
    .a_opcode_i  (auto_in.a_bits_opcode),
    .a_size_i    (auto_in.a_bits_size),
    .d_valid_o   (t_d_valid[N_OUT]),
    .d_ready_i   (d_valid_int & auto_in.d_ready[0] & (tgt_q == TGT_W'(N_OUT))),
    .d_opcode_o  (t_d_opcode[N_OUT]),
    .d_param_o   (t_d_param[N_OUT]),
    .d_size_o    (t_d_size[N_OUT]),
    .d_sink_o    (t_d_sink[N_OUT]),
    .d_denied_o  (t_d_denied[N_OUT]),
    .d_data_o    (t_d_data[N_OUT]),
    .d_corrupt_o (t_d_corrupt[N_OUT])
  );
`endif

  // Lowest matching index wins; no match falls back to UNMAPPED.
  always_comb begin
    dec_idx = TGT_W'(UNMAPPED);
    found   = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (!found && (((auto_in.a_bits_address ^ ADDR_BASE[i*ADDR_W +: ADDR_W]) &
                      ~ADDR_MASK[i*ADDR_W +: ADDR_W]) == '0)) begin
        found   = 1'b1;
        dec_idx = TGT_W'(i);
      end
    end
  end

  assign tgt_eff = (a_beats_q != '0) ? tgt_q : dec_idx;
  assign admit   = (a_beats_q != '0) ||
                   ((out_q < OUT_W'(MAX_OUT)) && (!locked_q || (dec_idx == tgt_q)));
  assign a_go        = reset & auto_in.a_valid[0] & admit;
  assign a_ready_int = reset & admit & t_a_ready[tgt_eff];
  // Responses are only meaningful while something is outstanding.
  assign d_valid_int = reset & (out_q != '0) & t_d_valid[tgt_q];

  assign auto_in.a_ready[0]        = a_ready_int;
  assign auto_in.d_valid[0]        = d_valid_int;
  assign auto_in.d_bits_opcode     = t_d_opcode[tgt_q];
  assign auto_in.d_bits_param      = t_d_param[tgt_q];
  assign auto_in.d_bits_size       = t_d_size[tgt_q];
  assign auto_in.d_bits_sink       = t_d_sink[tgt_q];
  assign auto_in.d_bits_denied[0]  = t_d_denied[tgt_q];
  assign auto_in.d_bits_data       = t_d_data[tgt_q];
  assign auto_in.d_bits_corrupt[0] = t_d_corrupt[tgt_q];

  assign auto_out.a_bits_opcode  = {N_OUT{auto_in.a_bits_opcode}};
  assign auto_out.a_bits_size    = {N_OUT{auto_in.a_bits_size}};
  assign auto_out.a_bits_address = {N_OUT{auto_in.a_bits_address}};
  assign auto_out.a_bits_mask    = {N_OUT{auto_in.a_bits_mask}};
  assign auto_out.a_bits_data    = {N_OUT{auto_in.a_bits_data}};

  assign a_fire  = auto_in.a_valid[0] & a_ready_int;
  assign d_fire  = d_valid_int & auto_in.d_ready[0];
  assign a_first = has_data_a(auto_in.a_bits_opcode) ?
                   num_beats(32'(auto_in.a_bits_size), DATA_W) : BEAT_W'(1);
  assign d_first = has_data_d(t_d_opcode[tgt_q]) ?
                   num_beats(32'(t_d_size[tgt_q]), DATA_W) : BEAT_W'(1);
  assign a_last  = (a_beats_q == '0) ? (a_first == BEAT_W'(1)) : (a_beats_q == BEAT_W'(1));
  assign d_last  = (d_beats_q == '0) ? (d_first == BEAT_W'(1)) : (d_beats_q == BEAT_W'(1));

  always_comb begin
    tgt_d     = tgt_q;
    a_beats_d = a_beats_q;
    d_beats_d = d_beats_q;
    out_d     = out_q;
    if (a_fire) begin
      if (a_beats_q == '0) begin
        tgt_d     = dec_idx;
        a_beats_d = a_first - BEAT_W'(1);
      end else begin
        a_beats_d = a_beats_q - BEAT_W'(1);
      end
    end
    if (d_fire) begin
      d_beats_d = (d_beats_q == '0) ? (d_first - BEAT_W'(1)) : (d_beats_q - BEAT_W'(1));
    end
    if ((a_fire && a_last) && !(d_fire && d_last)) begin
      out_d = out_q + OUT_W'(1);
    end else if (!(a_fire && a_last) && (d_fire && d_last)) begin
      out_d = out_q - OUT_W'(1);
    end
    locked_d = (out_d != '0) || (a_beats_d != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tgt_q     <= '0;
      out_q     <= '0;
      a_beats_q <= '0;
      d_beats_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      out_q     <= out_d;
      a_beats_q <= a_beats_d;
      d_beats_q <= d_beats_d;
      locked_q  <= locked_d;
    end
  end

endmodule

// File: doc/tl_xbar_demux.md
Name: tl_xbar_demux

Overview:
- Parametrised successor to the 1:1 TileLink-UL pass-through crossbar.
- Routes one client port to N_OUT manager ports by address decode on channel A.
- Multiplexes the selected manager's channel D back to the client.
- The client has no source field, so ordering is kept by a target lock and an outstanding-request counter. Sits between the periphery bus client and peripheral managers.

Parameters:
- N_OUT, 4, number of manager ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 64, data width; power of two ≥ 8.
- SIZE_W, 4, log2 transfer-size field width.
- SINK_W, 3, D sink width.
- MAX_OUT, 4, maximum in-flight requests (counter width clog2(MAX_OUT+1)).
- ADDR_BASE, N_OUT×ADDR_W packed, per-port base; port i in bits [i*ADDR_W +: ADDR_W].
- ADDR_MASK, N_OUT×ADDR_W packed, per-port don't-care mask. Port i hits when ((addr ^ base_i) & ~mask_i) == 0.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- auto_in_a_ready  out  1  client A ready.
- auto_in_a_valid  in  1  client A valid.
- auto_in_a_bits_{opcode,size,address,mask,data}  in  3/SIZE_W/ADDR_W/DATA_W/8/DATA_W  client A payload.
- auto_in_d_ready  in  1  client D ready.
- auto_in_d_valid  out  1  client D valid.
- auto_in_d_bits_{opcode,param,size,sink,denied,data,corrupt}  out  3/2/SIZE_W/SINK_W/1/DATA_W/1  client D payload.
- auto_out_a_ready  in  N_OUT  per-manager A ready.
- auto_out_a_valid  out  N_OUT  per-manager A valid.
- auto_out_a_bits_*  out  N_OUT×field  packed A payload, broadcast to every port.
- auto_out_d_ready  out  N_OUT  per-manager D ready.
- auto_out_d_valid  in  N_OUT  per-manager D valid.
- auto_out_d_bits_*  in  N_OUT×field  packed D payloads.

Behaviour:
- **Reset values:** while reset is low, auto_in_a_ready=0, auto_out_a_valid=0, auto_out_d_ready=0 and auto_in_d_valid=0. Registers clear to: tgt=0, outstanding=0, a_beats=0, d_beats=0, locked=0.
- **Decode:** one-hot hit vector over ports; lowest index wins on overlap. No hit means unmapped (see Optional Feature).
- **Latency:** A and D paths are purely combinational, zero cycles; the only registers are routing state. No buffering.
- **Beats:** beats = 2^size / (DATA_W/8), minimum 1.
  - A is multi-beat only for PutFullData (0) and PutPartialData (1).
  - D is multi-beat only for AccessAckData (1).
- **A admission** (first beat, a_beats==0). Accept iff all of:
  - outstanding < MAX_OUT;
  - outstanding==0 or decoded port == tgt.
- **On a first-beat fire:** tgt <= decoded port; load a_beats with beats-1.
- **Later beats of the same burst:** route to tgt regardless of address. Each fire decrements a_beats.
- **Handshake:** auto_in_a_ready = admit & auto_out_a_ready[tgt_eff]. auto_out_a_valid[tgt_eff] = auto_in_a_valid & admit; all other valids are 0. Valid never depends on the client's ready.
- **outstanding counter:**
  - +1 on the last A beat fire.
  - −1 on the last D beat fire.
  - Unchanged when both fire in the same cycle.
  - Never wraps; overflow is impossible by the admission rule.
- **D path:**
  - Client D fields come from tgt.
  - auto_out_d_ready[tgt] = auto_in_d_ready; all other D readies are 0.
  - d_beats tracks the response burst: loaded on the first fire, decremented per beat.
- **D valid with outstanding==0 from any port:** ignored (ready 0), never forwarded.
- **Ports:** combinational paths only; the FSM lives in the counters. States are:
  - IDLE: outstanding==0, a_beats==0.
  - BUSY: outstanding>0 or mid-burst; target locked.
- **Single-port build:** N_OUT=1 degenerates to a pass-through with the outstanding limit.

Optional Feature:
- Macro: TL_XBAR_ERROR_SLAVE_EN.
- **Defined:**
  - Unmapped requests go to an internal responder at index N_OUT.
  - The responder accepts all beats and then returns one response with denied=1, corrupt=1 for Get, param=0, size echoed.
  - Opcode is AccessAckData (1) for Get (4), otherwise AccessAck (0).
  - A Get response carries the full beat count with data=0.
- **Undefined:** unmapped requests are routed to port 0.

Decomposition:
- Shared package tl_xbar_pkg holds:
  - opcode constants (A: PUT_FULL=0, PUT_PARTIAL=1, GET=4; D: ACK=0, ACK_DATA=1);
  - function num_beats(size, DATA_W);
  - function has_data_a / has_data_d.
- One natural sub-module: tl_xbar_err_slave, the denied responder, instantiated only under the macro.

Test Plan:
- **Basic routing:** N_OUT=4 with bases 0x1000/0x2000/0x3000/0x4000 and mask 0xFFF. Send Get to 0x2010 with size=3 → auto_out_a_valid=4'b0010, one D beat returned from port 1 with the same data.
- **Target lock:** Get to port 0 outstanding, then Get to 0x3000 → auto_in_a_ready=0 until port 0's D fires, then routed to port 2 the next cycle.
- **Outstanding limit:** MAX_OUT=4, five Gets to port 1 with D stalled → the fifth is held (a_ready=0). Release one D → the fifth is accepted; outstanding returns to 4.
- **Burst lock:** PutFullData size=5 to 0x1000 (4 beats, second beat address 0x4000) → all 4 beats go to port 0, then exactly one AccessAck.
- **Simultaneous events and reset:**
  - Last D fire and new A fire in the same cycle → outstanding unchanged.
  - Reset driven low mid-burst → all valids and readies are 0 immediately and counters are 0.
- **Unmapped address:** Get to 0x8000.
  - With TL_XBAR_ERROR_SLAVE_EN: D opcode=1, denied=1, corrupt=1.
  - Without it: routed to port 0.
